// File: rtl/cpu24_pkg.sv
// -----------------------------------------------------------------------------
// cpu24_pkg
// Shared constants and types for the 24-bit datapath blocks that sit beside
// the ALU24bit unit.
//   CPU_WIDTH     datapath word width
//   DIV_CNT_W     width of the divider iteration counter
//   div_state_t   divider control states (IDLE / CALC / DONE)
//   DIV_BYZERO_Q  quotient reported when the divisor is zero
// -----------------------------------------------------------------------------
package cpu24_pkg;

    localparam int CPU_WIDTH = 24;
    localparam int DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [CPU_WIDTH-1:0] DIV_BYZERO_Q = 24'hFFFFFF;

endpackage : cpu24_pkg

// File: rtl/div24_step.sv
// -----------------------------------------------------------------------------
// div24_step
// One combinational iteration of a restoring radix-2 divider.
// The partial remainder is shifted left by one with the next dividend bit
// appended, then the divisor is trial-subtracted. The subtraction is one bit
// wider than the operands so divisors above 2^(WIDTH-1) never lose a carry.
//
// Ports
//   r_i             current partial remainder (always < divisor_i)
//   dividend_msb_i  next dividend bit shifted into the remainder
//   divisor_i       divisor magnitude
//   r_next_o        partial remainder after this iteration
//   q_bit_o         quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div24_step
    import cpu24_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic             dividend_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] r_next_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign trial = {r_i, dividend_msb_i};
    assign diff  = trial - {1'b0, divisor_i};

    // Because r_i < divisor_i, trial < 2*divisor, so a non-negative
    // difference always fits in WIDTH bits and the top bit is a pure borrow.
    assign q_bit_o  = ~diff[WIDTH];
    assign r_next_o = q_bit_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule : div24_step

// File: rtl/div24_seq_unit.sv
// -----------------------------------------------------------------------------
// div24_seq_unit
// Multi-cycle integer divider, companion of the ALU24bit multiply path.
// Restoring radix-2, one quotient bit per clock, fixed latency of WIDTH
// cycles from the accepting edge to the Done cycle (one cycle for a zero
// divisor). The control unit stalls the PC while Busy is high.
//
// Optional feature macro: DIV24_SIGNED_EN
//   defined   : Signed=1 divides two's-complement operands (quotient rounds
//               toward zero, remainder follows the dividend sign)
//   undefined : Signed is ignored, every division is unsigned
//
// Ports
//   Clock      system clock, rising edge
//   Reset      asynchronous active-low reset
//   Start      request pulse, accepted only when not Busy
//   Dividend   numerator, captured on an accepted Start
//   Divisor    denominator, captured on an accepted Start
//   Signed     two's-complement request (only with DIV24_SIGNED_EN)
//   Busy       high while an iteration sequence is running
//   Done       one-cycle completion pulse, results valid from this cycle
//   Quotient   result, held until the next completion
//   Remainder  result, held until the next completion
//   DivByZero  set with Done for a zero divisor, cleared on next accept
// -----------------------------------------------------------------------------
module div24_seq_unit
    import cpu24_pkg::*;
#(
    parameter int WIDTH = CPU_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    input  logic             Signed,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam logic [WIDTH-1:0] BYZERO_Q = WIDTH'(DIV_BYZERO_Q);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state_q;
    div_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;

    // dq_q starts as the dividend magnitude; each iteration shifts one
    // dividend bit out of the top and one quotient bit into the bottom.
    logic [WIDTH-1:0] dq_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] rem_q;

    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] remo_q;
    logic             dbz_q;

    logic             accept;
    logic             dvsr_zero;
    logic             last_step;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic [WIDTH-1:0] r_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_raw;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign accept    = Start && (state_q != CALC);
    assign dvsr_zero = (Divisor == '0);
    assign last_step = (state_q == CALC) && (cnt_q == '0);
    assign q_raw     = {dq_q[WIDTH-2:0], q_bit};

    div24_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_i            (rem_q),
        .dividend_msb_i (dq_q[WIDTH-1]),
        .divisor_i      (dsr_q),
        .r_next_o       (r_next),
        .q_bit_o        (q_bit)
    );

`ifdef DIV24_SIGNED_EN
    logic dvd_neg;
    logic dsr_neg;
    logic q_neg_q;
    logic r_neg_q;

    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                     input logic             neg);
        logic signed [WIDTH-1:0] s;
        s = $signed(v);
        return neg ? $unsigned(-s) : v;
    endfunction

    assign dvd_neg = Signed & Dividend[WIDTH-1];
    assign dsr_neg = Signed & Divisor[WIDTH-1];
    assign dvd_mag = cond_negate(Dividend, dvd_neg);
    assign dsr_mag = cond_negate(Divisor, dsr_neg);

    // Sign flags travel with the operands; the most negative dividend
    // becomes 2^(WIDTH-1) as an unsigned magnitude, so -2^23/-1 wraps.
    always_ff @(posedge Clock) begin
        if (accept) begin
            q_neg_q <= dvd_neg ^ dsr_neg;
            r_neg_q <= dvd_neg;
        end
    end

    // Sign correction sits on the last iteration's result path so the
    // latency matches the unsigned case.
    assign q_fix = cond_negate(q_raw, q_neg_q);
    assign r_fix = cond_negate(r_next, r_neg_q);
`else
    logic unused_signed;

    assign unused_signed = Signed;
    assign dvd_mag       = Dividend;
    assign dsr_mag       = Divisor;
    assign q_fix         = q_raw;
    assign r_fix         = r_next;
`endif

    // ---------------- control: state register ----------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- control: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = dvsr_zero ? DONE : CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- control: outputs ----------------
    always_comb begin
        Busy = (state_q == CALC);
        Done = (state_q == DONE);
    end

    // ---------------- iteration counter ----------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else if (accept && !dvsr_zero) begin
            cnt_q <= CNT_LAST;
        end else if ((state_q == CALC) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // ---------------- working registers ----------------
    always_ff @(posedge Clock) begin
        if (accept) begin
            dq_q  <= dvd_mag;
            dsr_q <= dsr_mag;
            rem_q <= '0;
        end else if (state_q == CALC) begin
            dq_q  <= q_raw;
            rem_q <= r_next;
        end
    end

    // ---------------- result registers ----------------
    // Results only move at the edge that enters DONE, so the working
    // registers are never exposed mid-operation.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            quot_q <= '0;
            remo_q <= '0;
            dbz_q  <= 1'b0;
        end else if (accept) begin
            if (dvsr_zero) begin
                quot_q <= BYZERO_Q;
                remo_q <= Dividend;
                dbz_q  <= 1'b1;
            end else begin
                dbz_q  <= 1'b0;
            end
        end else if (last_step) begin
            quot_q <= q_fix;
            remo_q <= r_fix;
        end
    end

    assign Quotient  = quot_q;
    assign Remainder = remo_q;
    assign DivByZero = dbz_q;

endmodule : div24_seq_unit
